// File: rtl/seq_mul.sv
// Sequential 4x4 unsigned shift-and-add multiplier.
// Load captures both operands; four following edges each retire one multiplier bit.
module seq_mul (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] y
);

  logic [7:0] ra;
  logic [3:0] rb;
  logic [7:0] ry;
  logic [2:0] cnt;

  logic       w_run;
  logic [7:0] w_sum;

  // cnt doubles as the state: nonzero means steps remain
  assign w_run = (cnt != 3'd0);
  assign w_sum = rb[0] ? (ry + ra) : ry;

  // Load has priority over stepping; idle holds everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ra  <= 8'd0;
      rb  <= 4'd0;
      ry  <= 8'd0;
      cnt <= 3'd0;
    end else if (ld) begin
      ra  <= {4'd0, a};
      rb  <= b;
      ry  <= 8'd0;
      cnt <= 3'd4;
    end else if (w_run) begin
      ry  <= w_sum;
      ra  <= {ra[6:0], 1'b0};
      rb  <= {1'b0, rb[3:1]};
      cnt <= cnt - 3'd1;
    end else begin
      ra  <= ra;
      rb  <= rb;
      ry  <= ry;
      cnt <= cnt;
    end
  end

  assign y = ry;

endmodule

// File: tb/tb_seq_mul.sv
// Self-checking bench for seq_mul against an arithmetic reference model.
module tb_seq_mul;

  logic       clk;
  logic       rst;
  logic       ld;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] y;

  int n_tests;
  int n_fail;

  seq_mul dut (
    .clk (clk),
    .rst (rst),
    .ld  (ld),
    .a   (a),
    .b   (b),
    .y   (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Partial product after k steps: multiplicand times the low k multiplier bits
  function automatic logic [7:0] ref_partial(input int av, input int bv, input int k);
    return 8'(av * (bv % (1 << k)));
  endfunction

  // Loads one operand pair; returns at the falling edge just after the load edge
  task automatic do_load(input logic [3:0] av, input logic [3:0] bv);
    ld = 1'b1;
    a  = av;
    b  = bv;
    @(posedge clk);
    @(negedge clk);
    ld = 1'b0;
    a  = 4'd0;
    b  = 4'd0;
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    ld  = 1'b0;
    a   = 4'd0;
    b   = 4'd0;
    repeat (3) step();
    n_tests++;
    if (y !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_y: got %0d want 0", y);
    end
    n_tests++;
    if (dut.ra !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_ra: got %0d want 0", dut.ra);
    end
    n_tests++;
    if (dut.cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d want 0", dut.cnt);
    end
    rst = 1'b1;
    repeat (3) step();
    n_tests++;
    if (y !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_release_y: got %0d want 0", y);
    end
  endtask

  task automatic test_steps(input logic [3:0] av, input logic [3:0] bv);
    logic [7:0] exp_ra;
    do_load(av, bv);
    n_tests++;
    if (y !== 8'd0) begin
      n_fail++;
      $display("FAIL load_clear %0dx%0d: got %0d want 0", av, bv, y);
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      exp_ra = 8'(int'(av) << k);
      n_tests++;
      if (dut.ry !== ref_partial(av, bv, k)) begin
        n_fail++;
        $display("FAIL step_ry %0dx%0d k=%0d: got %0d want %0d", av, bv, k, dut.ry, ref_partial(av, bv, k));
      end
      n_tests++;
      if (dut.ra !== exp_ra) begin
        n_fail++;
        $display("FAIL step_ra %0dx%0d k=%0d: got %0d want %0d", av, bv, k, dut.ra, exp_ra);
      end
    end
    repeat (3) step();
    n_tests++;
    if (y !== 8'(av * bv)) begin
      n_fail++;
      $display("FAIL hold %0dx%0d: got %0d want %0d", av, bv, y, av * bv);
    end
  endtask

  task automatic test_products;
    logic [3:0] pa [6] = '{4'd9, 4'd15, 4'd0, 4'd9, 4'd1, 4'd15};
    logic [3:0] pb [6] = '{4'd6, 4'd15, 4'd9, 4'd0, 4'd1, 4'd1};
    for (int i = 0; i < 6; i++) begin
      do_load(pa[i], pb[i]);
      repeat (4) step();
      n_tests++;
      if (y !== 8'(pa[i] * pb[i])) begin
        n_fail++;
        $display("FAIL product %0dx%0d: got %0d want %0d", pa[i], pb[i], y, pa[i] * pb[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] av;
    logic [3:0] bv;
    for (int i = 0; i < 24; i++) begin
      av = 4'($urandom_range(0, 15));
      bv = 4'($urandom_range(0, 15));
      do_load(av, bv);
      repeat (4) step();
      n_tests++;
      if (y !== 8'(av * bv)) begin
        n_fail++;
        $display("FAIL b2b %0dx%0d: got %0d want %0d", av, bv, y, av * bv);
      end
    end
  endtask

  task automatic test_held_load;
    ld = 1'b1;
    a  = 4'd3;
    b  = 4'd5;
    step();
    a  = 4'd7;
    b  = 4'd2;
    step();
    n_tests++;
    if (y !== 8'd0 || dut.cnt !== 3'd4) begin
      n_fail++;
      $display("FAIL held_reload: got y=%0d cnt=%0d want y=0 cnt=4", y, dut.cnt);
    end
    ld = 1'b0;
    a  = 4'd0;
    b  = 4'd0;
    repeat (4) step();
    n_tests++;
    if (y !== 8'd14) begin
      n_fail++;
      $display("FAIL held_product: got %0d want 14", y);
    end
  endtask

  task automatic test_restart;
    int seen_stale;
    seen_stale = 0;
    do_load(4'd13, 4'd11);
    step();
    if (y === 8'd143) seen_stale++;
    do_load(4'd9, 4'd6);
    for (int k = 1; k <= 4; k++) begin
      step();
      if (y === 8'd143) seen_stale++;
    end
    n_tests++;
    if (seen_stale != 0) begin
      n_fail++;
      $display("FAIL restart_stale: got %0d cycles showing 143 want 0", seen_stale);
    end
    n_tests++;
    if (y !== 8'd54) begin
      n_fail++;
      $display("FAIL restart_product: got %0d want 54", y);
    end
  endtask

  task automatic test_reset_mid;
    do_load(4'd13, 4'd11);
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if (y !== 8'd0 || dut.cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_mid: got y=%0d cnt=%0d want 0 0", y, dut.cnt);
    end
    step();
    rst = 1'b1;
    repeat (5) step();
    n_tests++;
    if (y !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_mid_after: got %0d want 0", y);
    end
    do_load(4'd7, 4'd7);
    repeat (4) step();
    n_tests++;
    if (y !== 8'd49) begin
      n_fail++;
      $display("FAIL rst_mid_reload: got %0d want 49", y);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_steps(4'd13, 4'd11);
    test_steps(4'd9, 4'd6);
    test_products();
    test_back_to_back();
    test_held_load();
    test_restart();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
